// File: rtl/controle_microondas.sv
// Microwave sequencing controller: owns the MM:SS BCD time register and the
// IDLE/RUN/PAUSE/DONE cooking state machine fed by keypad, buttons and a 1 Hz tick.
module controle_microondas #(
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       enablen,
  output logic       mag_on,
  output logic       done,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] raw;
  logic [3:0] dly_reg;
  logic [3:0] evt_reg;
  logic [3:0] key_code_reg;
  logic       key_evt, start_evt, stop_evt, tick_evt;
  logic [3:0] tm_reg  [4];
  logic [3:0] tm_next [4];
  logic [3:0] dec_tm  [4];
  logic       time_zero, dec_zero;
  logic [1:0] cnt_reg, cnt_next;

  // pgt_1Hz is inverted so every event is a falling edge of its raw bit
  assign raw = {loadn, startn, stopn, ~pgt_1Hz};
  assign {key_evt, start_evt, stop_evt, tick_evt} = evt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dly_reg      <= 4'hF;
      evt_reg      <= 4'h0;
      key_code_reg <= 4'h0;
    end else begin
      dly_reg <= raw;
      evt_reg <= dly_reg & ~raw;
      if (dly_reg[3] && !raw[3]) key_code_reg <= D;
    end
  end

  // BCD countdown with borrow; index 3 = min_t ... index 0 = sec_u
  always_comb begin
    dec_tm = tm_reg;
    if (tm_reg[0] != 4'd0) begin
      dec_tm[0] = tm_reg[0] - 4'd1;
    end else begin
      dec_tm[0] = 4'd9;
      if (tm_reg[1] != 4'd0) begin
        dec_tm[1] = tm_reg[1] - 4'd1;
      end else begin
        dec_tm[1] = 4'd5;
        if (tm_reg[2] != 4'd0) begin
          dec_tm[2] = tm_reg[2] - 4'd1;
        end else begin
          dec_tm[2] = 4'd9;
          dec_tm[3] = tm_reg[3] - 4'd1;
        end
      end
    end
  end

  assign time_zero = ((tm_reg[3] | tm_reg[2] | tm_reg[1] | tm_reg[0]) == 4'd0);
  assign dec_zero  = ((dec_tm[3] | dec_tm[2] | dec_tm[1] | dec_tm[0]) == 4'd0);

  always_comb begin
    state_next = state_reg;
    tm_next    = tm_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (stop_evt) begin
          for (int i = 0; i < 4; i++) tm_next[i] = 4'd0;
        end else if (start_evt && door_closed && !time_zero) begin
          state_next = S_RUN;
        end else if (key_evt && key_code_reg <= 4'd9) begin
          tm_next[3] = tm_reg[2];
          tm_next[2] = tm_reg[1];
          tm_next[1] = tm_reg[0];
          tm_next[0] = key_code_reg;
        end
      end
      S_RUN: begin
        if (!door_closed || stop_evt) begin
          state_next = S_PAUSE;
        end else if (tick_evt && !time_zero) begin
          tm_next = dec_tm;
          if (dec_zero) begin
            state_next = S_DONE;
            cnt_next   = 2'd0;
          end
        end
      end
      S_PAUSE: begin
        if (stop_evt) begin
          state_next = S_IDLE;
          for (int i = 0; i < 4; i++) tm_next[i] = 4'd0;
        end else if (start_evt && door_closed) begin
          state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (!door_closed || stop_evt) begin
          state_next = S_IDLE;
          cnt_next   = 2'd0;
        end else if (tick_evt) begin
          if (cnt_reg == 2'(DONE_TICKS - 1)) begin
            state_next = S_IDLE;
            cnt_next   = 2'd0;
          end else begin
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_reg exactly
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      tm_reg    <= '{default: 4'd0};
      cnt_reg   <= 2'd0;
      enablen   <= 1'b0;
      mag_on    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      tm_reg    <= tm_next;
      cnt_reg   <= cnt_next;
      enablen   <= (state_next != S_IDLE);
      mag_on    <= (state_next == S_RUN);
      done      <= (state_next == S_DONE);
    end
  end

  assign min_t = tm_reg[3];
  assign min_u = tm_reg[2];
  assign sec_t = tm_reg[1];
  assign sec_u = tm_reg[0];
  assign state = state_reg;

endmodule

// File: tb/tb_controle_microondas.sv
// Bench for controle_microondas: directed vector table, hand-written corner
// sequences, then randomized stimulus against a decimal-arithmetic model.
module tb_controle_microondas;

  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] D;
  logic       loadn, pgt_1Hz, startn, stopn, door_closed;
  logic       enablen, mag_on, done;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic [1:0] state;

  controle_microondas #(.DONE_TICKS(DT)) dut (
    .clk(clk), .resetn(resetn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .startn(startn), .stopn(stopn), .door_closed(door_closed),
    .enablen(enablen), .mag_on(mag_on), .done(done),
    .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         n;
    logic       l, s, p, pg, dr;
    logic [3:0] d;
    logic [1:0] st;
    logic [15:0] tm;
    logic       mag, dn, en;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, logic l, logic s, logic p, logic pg, logic dr,
                              logic [3:0] d, logic [1:0] st, logic [15:0] tm,
                              logic mag, logic dn, logic en);
    vec_t v;
    v.n = n; v.l = l; v.s = s; v.p = p; v.pg = pg; v.dr = dr; v.d = d;
    v.st = st; v.tm = tm; v.mag = mag; v.dn = dn; v.en = en;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic l, logic s, logic p, logic pg, logic dr, logic [3:0] d);
    loadn = l; startn = s; stopn = p; pgt_1Hz = pg; door_closed = dr; D = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dut_time();
    return {min_t, min_u, sec_t, sec_u};
  endfunction

  task automatic check_all(string tag, logic [1:0] st, logic [15:0] tm,
                           logic mag, logic dn, logic en);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_time"}, 32'(dut_time()), 32'(tm));
    check({tag, "_mag_on"}, 32'(mag_on), 32'(mag));
    check({tag, "_done"}, 32'(done), 32'(dn));
    check({tag, "_enablen"}, 32'(enablen), 32'(en));
  endtask

  task automatic key(logic [3:0] d);
    drive(0, 1, 1, 0, 1, d); cyc();
    drive(1, 1, 1, 0, 1, d); cyc(); cyc();
  endtask

  task automatic start_btn();
    drive(1, 0, 1, 0, 1, 0); cyc();
    drive(1, 1, 1, 0, 1, 0); cyc(); cyc();
  endtask

  task automatic tick();
    drive(1, 1, 1, 1, 1, 0); cyc();
    drive(1, 1, 1, 0, 1, 0); cyc(); cyc();
  endtask

  task automatic do_reset();
    drive(1, 1, 1, 0, 1, 0);
    resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
  endtask

  // Reference model: time held as a decimal MMSS number, mode 0..3
  int m_mode, m_tval, m_cnt;

  task automatic model_apply(logic k, logic s, logic st, logic t, logic [3:0] d, logic door);
    int mins, secs;
    case (m_mode)
      0: begin
        if (st) m_tval = 0;
        else if (s && door && m_tval != 0) m_mode = 1;
        else if (k && d <= 9) m_tval = (m_tval % 1000) * 10 + int'(d);
      end
      1: begin
        if (!door || st) m_mode = 2;
        else if (t && m_tval != 0) begin
          mins = m_tval / 100;
          secs = m_tval % 100;
          if (secs > 0) secs--;
          else begin secs = 59; mins--; end
          m_tval = mins * 100 + secs;
          if (m_tval == 0) begin m_mode = 3; m_cnt = 0; end
        end
      end
      2: begin
        if (st) begin m_mode = 0; m_tval = 0; end
        else if (s && door) m_mode = 1;
      end
      default: begin
        if (!door || st) m_mode = 0;
        else if (t) begin
          m_cnt++;
          if (m_cnt == DT) begin m_mode = 0; m_cnt = 0; end
        end
      end
    endcase
  endtask

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    logic c_l, c_s, c_p, c_pg, c_dr;
    logic [3:0] c_d;
    logic pv_l, pv_s, pv_p, pv_pg;
    logic e_k, e_s, e_p, e_t, q_k, q_s, q_p, q_t;
    logic [3:0] q_d;

    // columns: cycles, loadn, startn, stopn, pgt, door, D | state, time, mag, done, enablen
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd0, 16'h0000, 0,0,0));
    tbl.push_back(mk(1, 0,1,1,0,1, 4'h1, 2'd0, 16'h0000, 0,0,0));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h1, 2'd0, 16'h0001, 0,0,0));
    tbl.push_back(mk(1, 0,1,1,0,1, 4'h3, 2'd0, 16'h0001, 0,0,0));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h3, 2'd0, 16'h0013, 0,0,0));
    tbl.push_back(mk(2, 0,1,1,0,1, 4'h0, 2'd0, 16'h0130, 0,0,0));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd0, 16'h0130, 0,0,0));
    tbl.push_back(mk(1, 0,1,1,0,1, 4'hC, 2'd0, 16'h0130, 0,0,0));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'hC, 2'd0, 16'h0130, 0,0,0));
    tbl.push_back(mk(1, 1,0,1,0,0, 4'h0, 2'd0, 16'h0130, 0,0,0));
    tbl.push_back(mk(2, 1,1,1,0,0, 4'h0, 2'd0, 16'h0130, 0,0,0));
    tbl.push_back(mk(1, 1,0,1,0,1, 4'h0, 2'd0, 16'h0130, 0,0,0));
    tbl.push_back(mk(1, 1,1,1,0,1, 4'h0, 2'd1, 16'h0130, 1,0,1));
    tbl.push_back(mk(1, 1,1,1,1,1, 4'h0, 2'd1, 16'h0130, 1,0,1));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd1, 16'h0129, 1,0,1));
    tbl.push_back(mk(1, 1,1,0,1,1, 4'h0, 2'd1, 16'h0129, 1,0,1));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd2, 16'h0129, 0,0,1));
    tbl.push_back(mk(1, 1,1,1,1,1, 4'h0, 2'd2, 16'h0129, 0,0,1));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd2, 16'h0129, 0,0,1));
    tbl.push_back(mk(1, 1,0,1,0,1, 4'h0, 2'd2, 16'h0129, 0,0,1));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd1, 16'h0129, 1,0,1));
    tbl.push_back(mk(1, 1,1,1,1,1, 4'h0, 2'd1, 16'h0129, 1,0,1));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd1, 16'h0128, 1,0,1));
    tbl.push_back(mk(1, 1,1,1,0,0, 4'h0, 2'd2, 16'h0128, 0,0,1));
    tbl.push_back(mk(1, 1,1,1,1,0, 4'h0, 2'd2, 16'h0128, 0,0,1));
    tbl.push_back(mk(2, 1,1,1,0,0, 4'h0, 2'd2, 16'h0128, 0,0,1));
    tbl.push_back(mk(1, 1,0,1,0,1, 4'h0, 2'd2, 16'h0128, 0,0,1));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd1, 16'h0128, 1,0,1));
    tbl.push_back(mk(1, 1,1,0,0,1, 4'h0, 2'd1, 16'h0128, 1,0,1));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd2, 16'h0128, 0,0,1));
    tbl.push_back(mk(1, 1,1,0,0,1, 4'h0, 2'd2, 16'h0128, 0,0,1));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd0, 16'h0000, 0,0,0));
    tbl.push_back(mk(1, 1,0,1,0,1, 4'h0, 2'd0, 16'h0000, 0,0,0));
    tbl.push_back(mk(2, 1,1,1,0,1, 4'h0, 2'd0, 16'h0000, 0,0,0));

    drive(1, 1, 1, 0, 1, 0);
    resetn = 1'b0;
    #2;
    check_all("reset", 2'd0, 16'h0000, 0, 0, 0);
    cyc(); cyc();
    resetn = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].l, tbl[r].s, tbl[r].p, tbl[r].pg, tbl[r].dr, tbl[r].d);
      for (int c = 0; c < tbl[r].n; c++) cyc();
      $display("row %0d state=%0d time=%04h mag_on=%0b done=%0b enablen=%0b",
               r, state, dut_time(), mag_on, done, enablen);
      check_all($sformatf("row%0d", r), tbl[r].st, tbl[r].tm, tbl[r].mag, tbl[r].dn, tbl[r].en);
    end

    // Full 01:00 cook through DONE and the hold period
    key(4'd1); key(4'd0); key(4'd0);
    check_all("cook_entry", 2'd0, 16'h0100, 0, 0, 0);
    start_btn();
    check_all("cook_start", 2'd1, 16'h0100, 1, 0, 1);
    tick();
    $display("cook first tick time=%04h", dut_time());
    check_all("cook_tick1", 2'd1, 16'h0059, 1, 0, 1);
    for (int i = 0; i < 58; i++) tick();
    check_all("cook_0001", 2'd1, 16'h0001, 1, 0, 1);
    tick();
    $display("cook reached end state=%0d done=%0b", state, done);
    check_all("cook_done", 2'd3, 16'h0000, 0, 1, 1);
    tick(); tick();
    check_all("done_hold", 2'd3, 16'h0000, 0, 1, 1);
    tick();
    check_all("done_exit", 2'd0, 16'h0000, 0, 0, 0);

    // Asynchronous reset in the middle of a cook at 00:30
    key(4'd3); key(4'd0);
    start_btn();
    check_all("rst_run", 2'd1, 16'h0030, 1, 0, 1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    $display("async reset mid-run state=%0d mag_on=%0b", state, mag_on);
    check_all("rst_async", 2'd0, 16'h0000, 0, 0, 0);
    cyc();
    resetn = 1'b1;
    start_btn();
    check_all("rst_nostart", 2'd0, 16'h0000, 0, 0, 0);

    // Randomized run against the model
    do_reset();
    m_mode = 0; m_tval = 0; m_cnt = 0;
    q_k = 0; q_s = 0; q_p = 0; q_t = 0; q_d = 0;
    pv_l = 1; pv_s = 1; pv_p = 1; pv_pg = 0;
    for (int i = 0; i < 3000; i++) begin
      c_l = loadn; c_s = startn; c_p = stopn; c_pg = pgt_1Hz; c_dr = door_closed; c_d = D;
      if (loadn) begin
        if ($urandom_range(0, 5) == 0) begin
          c_l = 1'b0;
          c_d = 4'($urandom_range(0, 11));
        end else begin
          c_d = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 1) == 0) c_l = 1'b1;
      if (startn) c_s = ($urandom_range(0, 14) != 0);
      else if ($urandom_range(0, 1) == 0) c_s = 1'b1;
      if (stopn) c_p = ($urandom_range(0, 149) != 0);
      else if ($urandom_range(0, 1) == 0) c_p = 1'b1;
      if ($urandom_range(0, 2) == 0) c_pg = ~pgt_1Hz;
      if (door_closed) c_dr = ($urandom_range(0, 199) != 0);
      else c_dr = ($urandom_range(0, 3) == 0);

      e_k = pv_l & ~c_l;
      e_s = pv_s & ~c_s;
      e_p = pv_p & ~c_p;
      e_t = ~pv_pg & c_pg;
      drive(c_l, c_s, c_p, c_pg, c_dr, c_d);
      cyc();
      model_apply(q_k, q_s, q_p, q_t, q_d, c_dr);
      q_k = e_k; q_s = e_s; q_p = e_p; q_t = e_t; q_d = c_d;
      pv_l = c_l; pv_s = c_s; pv_p = c_p; pv_pg = c_pg;

      if (e_k || e_s || e_p || e_t)
        $display("rnd %0d key=%0b d=%0d start=%0b stop=%0b tick=%0b door=%0b state=%0d time=%04h",
                 i, e_k, c_d, e_s, e_p, e_t, c_dr, state, dut_time());
      check($sformatf("rnd%0d_state", i), 32'(state), 32'(m_mode));
      check($sformatf("rnd%0d_time", i), 32'(dut_time()), 32'(to_bcd(m_tval)));
      check($sformatf("rnd%0d_outs", i), 32'({enablen, mag_on, done}),
            32'({m_mode != 0, m_mode == 1, m_mode == 3}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_microondas.md
# controle_microondas

Sequencing controller for the microwave: consumes the time-entry block's outputs (BCD key code `D`, key-strobe `loadn`, 1 Hz timebase `pgt_1Hz`) plus the start/stop/door inputs. It owns the MM:SS BCD time register and the cooking state machine. It drives magnetron enable, the done indication, and `enablen` back to the time-entry block so keypad entry is accepted only while idle.

## Interface
Parameters:
- `DONE_TICKS`, 3: number of 1 Hz ticks `done` is held after countdown reaches 00:00.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `D`  in  4  BCD key code from the time-entry block; valid while `loadn`=0.
- `loadn`  in  1  low while a key is held; the falling edge is one key press.
- `pgt_1Hz`  in  1  1 Hz timebase; its rising edge is one second tick.
- `startn`  in  1  start button, active low; acts on the falling edge.
- `stopn`  in  1  stop/clear button, active low; acts on the falling edge.
- `door_closed`  in  1  1 = door closed (level).
- `enablen`  out  1  0 = keypad entry enabled (to time-entry block).
- `mag_on`  out  1  magnetron enable.
- `done`  out  1  end-of-cook indication.
- `min_t, min_u, sec_t, sec_u`  out  4 each  BCD time digits.
- `state`  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.

## Operation
- Every input (`loadn`, `startn`, `stopn`, `pgt_1Hz`) has a one-flop delay register. An edge is detected by comparing the input with its delayed copy: a key press is `loadn` going 1→0, a tick is `pgt_1Hz` going 0→1, a button press is the button going 1→0. Each detected edge lasts one cycle.
- IDLE (`enablen`=0):
  - Key press with `D`≤9: shift left, i.e. `min_t`←`min_u`, `min_u`←`sec_t`, `sec_t`←`sec_u`, `sec_u`←`D`.
  - `D`>9: ignored.
  - Start with `door_closed`=1 and time≠0000 → RUN. Otherwise start is ignored.
  - Stop clears all digits to 0.
- RUN (`mag_on`=1):
  - Each tick decrements the time in BCD. If `sec_u`=0 it wraps to 9 and borrows from `sec_t`. If `sec_t`=0 it wraps to 5 and borrows from minutes, using the same rule for `min_u`/`min_t` with `min_u` wrapping to 9.
  - `sec_t` entered above 5 (e.g. 00:90) counts down normally. 0000 is never decremented.
  - The tick that produces 0000 → DONE.
  - `door_closed`=0 → PAUSE.
  - Stop → PAUSE.
  - Key presses are ignored.
- PAUSE: time is frozen.
  - Start with door closed → RUN.
  - Stop → IDLE with digits cleared.
- DONE: `done`=1 and the digits stay at 0000.
  - A 2-bit tick counter counts `DONE_TICKS` ticks, then → IDLE.
  - Stop or door open → IDLE immediately.
- Same-cycle priority, highest first: resetn, door open, stop, tick, start, key. In RUN, a tick and a stop in the same cycle: the stop wins, the time is not decremented, and the next state is PAUSE.
- `enablen` = 0 only in IDLE; `mag_on` = 1 only in RUN; `done` = 1 only in DONE. All three are registered.

## Timing
- Reset, asynchronous: state IDLE, digits 0000, `enablen`=0, `mag_on`=0, `done`=0, edge registers 1 for `loadn`/`startn`/`stopn` and 0 for `pgt_1Hz`, DONE counter 0.
- Key press: the digit shift is visible 2 cycles after `loadn` falls (1 edge-detect register plus 1 update).
- Start/stop: state and outputs change 2 cycles after the button falls.
- Tick: the decrement is visible 2 cycles after `pgt_1Hz` rises.
- Door open: the door input is not edge-registered. It reaches `mag_on`=0 on the next clock edge (1 cycle).
- A held key or button produces exactly one action. It must return high before it can act again.
- `resetn` asserted mid-RUN drops `mag_on` asynchronously. Returning to RUN requires re-entering time and pressing start.

## Test plan
- Keys 1,3,0 (each press then release) in IDLE → digits 0,1,3,0. Then key code 4'hC → unchanged.
- Time 01:00, door closed, start, 1 tick → 00:59 with `mag_on`=1. 59 more ticks → DONE, `done`=1, `mag_on`=0. After 3 further ticks → IDLE.
- Time 00:05 in RUN, `door_closed`=0 → `mag_on`=0 on the next edge, state PAUSE, time frozen over 3 ticks. Close the door and press start → countdown resumes.
- In RUN, stop and tick in the same cycle → PAUSE, time unchanged. A second stop → IDLE, digits 0000.
- Start with time 0000, or with the door open → remains in IDLE, `mag_on`=0.
- Assert `resetn`=0 mid-RUN at 00:30 → outputs go to reset values immediately, without waiting for a clock edge.
